pulse_freq_meter: RTL and testbench
===================================

PULSE_FREQ_METER -- requirements
Module: pulse_freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter GATE_DIV, default 10, meaning gate window = CLK_FREQ/GATE_DIV cycles (100 ms at defaults).
REQ-003 SHALL have parameter MAX_FREQ, default 50000000, meaning highest reportable frequency in Hz; it sizes freq_o.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port arstn_i, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port en_i, input, 1, measurement enable, level-sensitive.
REQ-007 SHALL have port signal_i, input, 1, asynchronous pulse to measure (for example led_o of blink_led).
REQ-008 SHALL have port ack_i, input, 1, consumer acknowledge of the current result.
REQ-009 SHALL have port freq_o, output, FREQ_WIDTH = clog2(MAX_FREQ+1), measured frequency in Hz.
REQ-010 SHALL have port valid_o, output, 1, result available; held until acknowledged.
REQ-011 SHALL have port ovf_o, output, 1, sticky flag: saturation occurred in the reported window.
REQ-012 SHALL have port overrun_o, output, 1, sticky flag: an unacknowledged result was overwritten.

Function
REQ-013 SHALL pass signal_i through a 2-flop synchronizer followed by a rising-edge detector; detection latency is 3 clk_i edges.
REQ-014 SHALL implement the states IDLE, GATE and LATCH.
REQ-015 SHALL make these transitions: IDLE->GATE when en_i=1; GATE->LATCH after exactly GATE_CYCLES = CLK_FREQ/GATE_DIV cycles; LATCH->GATE if en_i=1, otherwise LATCH->IDLE.
REQ-016 SHALL count a rising edge detected on the last GATE cycle in the current window, and an edge detected during the LATCH cycle as the first edge of the next window (no edge lost between windows).
REQ-017 SHALL, in LATCH, set freq_o = edge_count*GATE_DIV and set valid_o=1 in the following cycle.
REQ-018 SHALL saturate edge_count at MAX_FREQ/GATE_DIV and set ovf_o for that window when further edges arrive; ovf_o is updated with each freq_o update.
REQ-019 SHALL, on en_i=0 during GATE, go to IDLE next cycle, discard the partial count, leave freq_o/valid_o unchanged and produce no result.
REQ-020 SHALL, on ack_i=1 while valid_o=1, clear valid_o next cycle; ack_i while valid_o=0 SHALL be ignored.
REQ-021 SHALL, if LATCH coincides with valid_o=1 and ack_i=0, overwrite freq_o, keep valid_o=1 and set overrun_o; overrun_o clears only on reset.
REQ-022 SHALL, when LATCH and ack_i arrive in the same cycle, treat the ack as consuming the old result: valid_o stays 1 (new result) and overrun_o is not set.
REQ-023 SHALL clear the gate counter and edge counter on entry to GATE from IDLE.
REQ-024 SHALL report freq_o=0 (valid) for a window with zero edges.

Reset
REQ-025 SHALL, when arstn_i=0 at a clk_i rising edge, set state=IDLE, freq_o=0, valid_o=0, ovf_o=0, overrun_o=0, clear all counters and set the synchronizer flops to 0.
REQ-026 SHALL, on reset during GATE or LATCH, abort and discard the window, including any pending result.
REQ-027 SHALL NOT count a rising edge on the first cycle after reset release when signal_i is already high at release.

Structure
REQ-028 SHALL place the state encoding (IDLE/GATE/LATCH) and a width helper for FREQ_WIDTH and the count width in the shared package pulse_gen_pkg.
REQ-029 SHALL implement the synchronizer plus edge detector as sub-module sync_edge_det, reusable by the step-control blocks.
REQ-030 SHALL be built with GATE_DIV dividing CLK_FREQ exactly; elaboration SHALL fail otherwise.

Verification (CLK_FREQ=1000, GATE_DIV=10, MAX_FREQ=1000: GATE_CYCLES=100, saturation at 100 edges)
REQ-031 Scenario: signal_i with a 10-clk period, en_i=1 -> freq_o=100, valid_o=1, ovf_o=0 after each window.
REQ-032 Scenario: signal_i toggles every clk (2-clk period = 50 edges per window) -> freq_o=500; then a constant-high input -> next freq_o=0.
REQ-033 Scenario: ack_i withheld across two windows -> second result overwrites the first and overrun_o=1; ack_i in the same cycle as LATCH -> overrun_o stays 0.
REQ-034 Scenario: en_i dropped at GATE cycle 50 -> IDLE, no valid_o, freq_o holds its previous value; re-enable -> full 100-cycle window.
REQ-035 Scenario: arstn_i=0 mid-GATE with signal_i high -> all outputs 0; after release, the first reported freq_o excludes the pre-reset high level.
REQ-036 Scenario: test build with MAX_FREQ=500 (saturation at 50 edges) and 60 edges per window -> freq_o=500, ovf_o=1.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generation / measurement blocks:
// meter FSM state encoding and a bit-width helper.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGate  = 2'd1,
    StLatch = 2'd2
  } meter_state_e;

  // Number of bits needed to hold any value in [0, value]; never less than 1.
  function automatic int unsigned bits_for(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge detector. A rise is reported
// three clock edges after it reaches async_i.
module sync_edge_det (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic async_i,
  output logic rise_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       rise_q, rise_d;
  logic [2:0] prime_q, prime_d;

  // prime_q stays incomplete until the synchronizer holds real samples, so a level
  // that was already high at reset release is taken as the baseline, not an edge.
  always_comb begin
    sync_d  = {sync_q[0], async_i};
    prev_d  = sync_q[1];
    prime_d = {prime_q[1:0], 1'b1};
    rise_d  = sync_q[1] & ~prev_q & prime_q[2];
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      prime_q <= prime_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/pulse_freq_meter.sv
// Gated frequency meter: counts rising edges of signal_i over a window of
// CLK_FREQ/GATE_DIV cycles and reports edges*GATE_DIV in Hz with a valid/ack handshake.
module pulse_freq_meter
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned GATE_DIV   = 10,
  parameter int unsigned MAX_FREQ   = 50000000,
  localparam int unsigned FREQ_WIDTH = bits_for(MAX_FREQ)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  en_i,
  input  logic                  signal_i,
  input  logic                  ack_i,
  output logic [FREQ_WIDTH-1:0] freq_o,
  output logic                  valid_o,
  output logic                  ovf_o,
  output logic                  overrun_o
);

  localparam int unsigned GATE_CYCLES = CLK_FREQ / GATE_DIV;
  localparam int unsigned MAX_EDGES   = MAX_FREQ / GATE_DIV;
  localparam int unsigned CNT_WIDTH   = bits_for(MAX_EDGES);
  localparam int unsigned GATE_WIDTH  = bits_for(GATE_CYCLES);

  localparam logic [GATE_WIDTH-1:0] GateLast = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  EdgeMax  = CNT_WIDTH'(MAX_EDGES);
  localparam logic [FREQ_WIDTH-1:0] DivW     = FREQ_WIDTH'(GATE_DIV);

  if ((CLK_FREQ % GATE_DIV) != 0 || GATE_CYCLES < 2) begin : gen_bad_gate_div
    $error("pulse_freq_meter: GATE_DIV must divide CLK_FREQ into a window of >= 2 cycles");
  end

  meter_state_e          state_q, state_d;
  logic [GATE_WIDTH-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic                  ovf_win_q, ovf_win_d;
  logic [FREQ_WIDTH-1:0] freq_q, freq_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  overrun_q, overrun_d;
  logic                  rise;

  sync_edge_det u_sync_edge_det (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .async_i (signal_i),
    .rise_o  (rise)
  );

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_win_d  = ovf_win_q;
    freq_d     = freq_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    overrun_d  = overrun_q;

    if (valid_q && ack_i) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_win_d  = 1'b0;
        end
      end
      StGate: begin
        if (!en_i) begin
          state_d = StIdle;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_WIDTH'(1);
          if (rise) begin
            if (edge_cnt_q == EdgeMax) ovf_win_d = 1'b1;
            else                       edge_cnt_d = edge_cnt_q + CNT_WIDTH'(1);
          end
          if (gate_cnt_q == GateLast) state_d = StLatch;
        end
      end
      StLatch: begin
        freq_d  = FREQ_WIDTH'(edge_cnt_q) * DivW;
        ovf_d   = ovf_win_q;
        valid_d = 1'b1;
        // A same-cycle ack consumes the old result, so only an unacked one is lost.
        if (valid_q && !ack_i) overrun_d = 1'b1;
        // The LATCH cycle is the first cycle of the next window, so back-to-back
        // windows stay exactly GATE_CYCLES long and no edge falls between them.
        gate_cnt_d = GATE_WIDTH'(1);
        edge_cnt_d = {{(CNT_WIDTH - 1){1'b0}}, rise};
        ovf_win_d  = 1'b0;
        state_d    = en_i ? StGate : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_win_q  <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_win_q  <= ovf_win_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      overrun_q  <= overrun_d;
    end
  end

  assign freq_o    = freq_q;
  assign valid_o   = valid_q;
  assign ovf_o     = ovf_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Directed bench for pulse_freq_meter: a 100-cycle-window instance and a
// 200-cycle-window instance with a lowered MAX_FREQ for saturation.
module tb_pulse_freq_meter;

  logic       clk;
  logic       rstn, en, sig, ack;
  logic [9:0] freq;
  logic       valid, ovf, overrun;
  logic       en2, sig2, ack2;
  logic [8:0] freq2;
  logic       valid2, ovf2, overrun2;

  int tests;
  int fails;
  int mode;
  int ph;

  pulse_freq_meter #(
    .CLK_FREQ (1000),
    .GATE_DIV (10),
    .MAX_FREQ (1000)
  ) u_dut (
    .clk_i     (clk),
    .arstn_i   (rstn),
    .en_i      (en),
    .signal_i  (sig),
    .ack_i     (ack),
    .freq_o    (freq),
    .valid_o   (valid),
    .ovf_o     (ovf),
    .overrun_o (overrun)
  );

  pulse_freq_meter #(
    .CLK_FREQ (2000),
    .GATE_DIV (10),
    .MAX_FREQ (500)
  ) u_dut_sat (
    .clk_i     (clk),
    .arstn_i   (rstn),
    .en_i      (en2),
    .signal_i  (sig2),
    .ack_i     (ack2),
    .freq_o    (freq2),
    .valid_o   (valid2),
    .ovf_o     (ovf2),
    .overrun_o (overrun2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode 0: low, 1: high, 2: 10-clk period, 3: toggle every clk
  initial begin
    sig = 1'b0;
    ph  = 0;
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        1:       sig = 1'b1;
        2:       sig = ((ph % 10) < 5);
        3:       sig = ~sig;
        default: sig = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_valid(output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (valid) begin
        ok     = 1'b1;
        waited = i;
        break;
      end
    end
  endtask

  task automatic get_result(output bit ok, output logic [9:0] f, output logic o);
    int w;
    wait_valid(ok, w);
    f   = freq;
    o   = ovf;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Drop whatever window was in flight when the stimulus changed.
  task automatic flush();
    bit         ok;
    logic [9:0] f;
    logic       o;
    repeat (5) @(negedge clk);
    if (valid) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    get_result(ok, f, o);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL flush_timeout: got no valid, want valid within 250 cycles");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (freq !== 10'd0) begin fails++; $display("FAIL reset_freq: got %0d want 0", freq); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (freq2 !== 9'd0) begin fails++; $display("FAIL reset_freq2: got %0d want 0", freq2); end
    rstn = 1'b1;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL ack_idle_valid: got %b want 0", valid); end
  endtask

  task automatic test_period10();
    bit         ok;
    logic [9:0] f;
    logic       o;
    mode = 2;
    en   = 1'b1;
    flush();
    for (int k = 0; k < 2; k++) begin
      get_result(ok, f, o);
      tests++; if (!ok || f !== 10'd100) begin fails++; $display("FAIL p10_freq: got %0d (valid seen %b) want 100", f, ok); end
      tests++; if (o !== 1'b0) begin fails++; $display("FAIL p10_ovf: got %b want 0", o); end
    end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL p10_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_toggle();
    bit         ok;
    logic [9:0] f;
    logic       o;
    mode = 3;
    flush();
    get_result(ok, f, o);
    tests++; if (!ok || f !== 10'd500) begin fails++; $display("FAIL toggle_freq: got %0d (valid seen %b) want 500", f, ok); end
    mode = 1;
    flush();
    get_result(ok, f, o);
    tests++; if (!ok || f !== 10'd0) begin fails++; $display("FAIL high_freq: got %0d (valid seen %b) want 0", f, ok); end
  endtask

  task automatic test_en_drop();
    bit         ok;
    bit         saw;
    int         w;
    logic [9:0] f;
    logic       o;
    get_result(ok, f, o);
    tests++; if (!ok || f !== 10'd0) begin fails++; $display("FAIL drop_pre_freq: got %0d (valid seen %b) want 0", f, ok); end
    mode = 3;
    repeat (48) @(negedge clk);
    en  = 1'b0;
    saw = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (valid) saw = 1'b1;
    end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL drop_no_valid: got valid %b want 0", saw); end
    tests++; if (freq !== 10'd0) begin fails++; $display("FAIL drop_hold_freq: got %0d want 0", freq); end
    en = 1'b1;
    wait_valid(ok, w);
    tests++; if (!ok || w != 102) begin fails++; $display("FAIL reen_latency: got %0d cycles want 102", w); end
    tests++; if (freq !== 10'd500) begin fails++; $display("FAIL reen_freq: got %0d want 500", freq); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    int w;
    mode = 2;
    flush();
    wait_valid(ok, w);
    repeat (105) @(negedge clk);
    tests++; if (!ok || valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    tests++; if (freq !== 10'd100) begin fails++; $display("FAIL ovr_freq: got %0d want 100", freq); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL ovr_ack_valid: got %b want 0", valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    flush();
    wait_valid(ok, w);
    repeat (99) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests++; if (!ok || valid !== 1'b1) begin fails++; $display("FAIL same_ack_valid: got %b want 1", valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL same_ack_overrun: got %b want 0", overrun); end
    tests++; if (freq !== 10'd100) begin fails++; $display("FAIL same_ack_freq: got %0d want 100", freq); end
  endtask

  task automatic test_reset_mid();
    bit         ok;
    logic [9:0] f;
    logic       o;
    mode = 1;
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    tests++; if (freq !== 10'd0) begin fails++; $display("FAIL mid_rst_freq: got %0d want 0", freq); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL mid_rst_ovf: got %b want 0", ovf); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
    rstn = 1'b1;
    get_result(ok, f, o);
    tests++; if (!ok || f !== 10'd0) begin fails++; $display("FAIL post_rst_freq: got %0d (valid seen %b) want 0", f, ok); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL post_rst_ovf: got %b want 0", o); end
    en   = 1'b0;
    mode = 0;
  endtask

  task automatic test_saturation();
    en2 = 1'b1;
    for (int c = 1; c <= 605; c++) begin
      @(negedge clk);
      if (c == 202) begin
        tests++; if (valid2 !== 1'b1 || freq2 !== 9'd500) begin fails++; $display("FAIL sat60_freq: got %0d valid %b want 500", freq2, valid2); end
        tests++; if (ovf2 !== 1'b1) begin fails++; $display("FAIL sat60_ovf: got %b want 1", ovf2); end
      end
      if (c == 402) begin
        tests++; if (valid2 !== 1'b1 || freq2 !== 9'd500) begin fails++; $display("FAIL sat50_freq: got %0d valid %b want 500", freq2, valid2); end
        tests++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL sat50_ovf: got %b want 0", ovf2); end
      end
      if (c == 602) begin
        tests++; if (valid2 !== 1'b1 || freq2 !== 9'd400) begin fails++; $display("FAIL sat40_freq: got %0d valid %b want 400", freq2, valid2); end
        tests++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL sat40_ovf: got %b want 0", ovf2); end
      end
      ack2 = (c == 202) || (c == 402) || (c == 602);
      sig2 = (((c >= 10) && (c <= 129)) || ((c >= 220) && (c <= 319)) ||
              ((c >= 420) && (c <= 499))) && ((c % 2) == 1);
    end
    tests++; if (overrun2 !== 1'b0) begin fails++; $display("FAIL sat_overrun: got %b want 0", overrun2); end
    en2 = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    en    = 1'b0;
    ack   = 1'b0;
    en2   = 1'b0;
    sig2  = 1'b0;
    ack2  = 1'b0;
    mode  = 0;
    tests = 0;
    fails = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_period10();
    test_toggle();
    test_en_drop();
    test_overrun();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
